// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - shared encodings and control bundle for the multi-cycle controller
package multicycle_control_fsm_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5,
      ST_BUSERR = 3'd6
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2a;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;
   localparam logic [3:0] ALU_LUI = 4'b1010;

   // mem_wr is internal only; it marks stores and drives dmem_wr during MEM
   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       ext_op;
      logic       mem_to_reg;
      logic       mem_wr;
      logic       branch;
      logic       branch_ne;
      logic       jump;
      logic       jal_instr;
      logic       mem_byte_op;
      logic       mem_halfword_op;
      logic       mem_sign_ext;
      logic [3:0] alu_ctrl;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - instruction/data memory request-acknowledge bundle
interface multicycle_control_fsm_if;
   logic [31:0] instr;
   logic        instr_req;
   logic        instr_ack;
   logic        dmem_req;
   logic        dmem_wr;
   logic        dmem_ack;

   modport master (
      output instr_req, dmem_req, dmem_wr,
      input  instr, instr_ack, dmem_ack
   );

   modport slave (
      input  instr_req, dmem_req, dmem_wr,
      output instr, instr_ack, dmem_ack
   );
endinterface

// File: rtl/multicycle_control_fsm_instr_decoder.sv
// rtl/multicycle_control_fsm_instr_decoder.sv - combinational opcode/funct to control bundle decode
module multicycle_control_fsm_instr_decoder
   import multicycle_control_fsm_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output ctrl_t      ctrl,
   output logic       illegal
);

   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_dst = 1'b1;
            case (funct)
               FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
               FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
               FN_AND:  ctrl.alu_ctrl = ALU_AND;
               FN_OR:   ctrl.alu_ctrl = ALU_OR;
               FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
               FN_SLL:  ctrl.alu_ctrl = ALU_SLL;
               FN_SRL:  ctrl.alu_ctrl = ALU_SRL;
               default: illegal = 1'b1;
            endcase
         end
         OP_ADDI: begin
            ctrl.alu_src  = 1'b1;
            ctrl.ext_op   = 1'b1;
            ctrl.alu_ctrl = ALU_ADD;
         end
         OP_ANDI: begin
            ctrl.alu_src  = 1'b1;
            ctrl.alu_ctrl = ALU_AND;
         end
         OP_ORI: begin
            ctrl.alu_src  = 1'b1;
            ctrl.alu_ctrl = ALU_OR;
         end
         OP_LUI: begin
            ctrl.alu_src  = 1'b1;
            ctrl.alu_ctrl = ALU_LUI;
         end
         OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
            ctrl.alu_src         = 1'b1;
            ctrl.ext_op          = 1'b1;
            ctrl.mem_to_reg      = 1'b1;
            ctrl.alu_ctrl        = ALU_ADD;
            ctrl.mem_byte_op     = (opcode == OP_LB) || (opcode == OP_LBU);
            ctrl.mem_halfword_op = (opcode == OP_LH) || (opcode == OP_LHU);
            ctrl.mem_sign_ext    = (opcode == OP_LB) || (opcode == OP_LH);
         end
         OP_SW, OP_SB, OP_SH: begin
            ctrl.alu_src         = 1'b1;
            ctrl.ext_op          = 1'b1;
            ctrl.mem_wr          = 1'b1;
            ctrl.alu_ctrl        = ALU_ADD;
            ctrl.mem_byte_op     = (opcode == OP_SB);
            ctrl.mem_halfword_op = (opcode == OP_SH);
         end
         OP_BEQ, OP_BNE: begin
            ctrl.ext_op    = 1'b1;
            ctrl.branch    = 1'b1;
            ctrl.branch_ne = (opcode == OP_BNE);
            ctrl.alu_ctrl  = ALU_SUB;
         end
         OP_J: begin
            ctrl.jump = 1'b1;
         end
         OP_JAL: begin
            ctrl.jump      = 1'b1;
            ctrl.jal_instr = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         ctrl = '0;
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with ack timeout and stall
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int TIMEOUT    = 16,
   parameter int ALU_CTRL_W = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     stall,
   multicycle_control_fsm_if.master bus,
   output logic                     ir_wr,
   output logic                     pc_wr,
   output logic                     reg_wr,
   output logic                     reg_dst,
   output logic                     alu_src,
   output logic                     ext_op,
   output logic                     mem_to_reg,
   output logic                     branch,
   output logic                     branch_ne,
   output logic                     jump,
   output logic                     jal_instr,
   output logic                     mem_byte_op,
   output logic                     mem_halfword_op,
   output logic                     mem_sign_ext,
   output logic [ALU_CTRL_W-1:0]    alu_ctrl,
   output logic                     illegal_instr,
   output logic                     bus_error,
   output logic [2:0]               state
);

   localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl_q, ctrl_d, dec_ctrl;
   logic             illegal_q, illegal_d, dec_illegal;
   logic             waiting;
   logic             unused_instr_bits;

   // Decoding the word at capture lets the registered controls be valid from DECODE on
   multicycle_control_fsm_instr_decoder u_decoder (
      .opcode  (bus.instr[31:26]),
      .funct   (bus.instr[5:0]),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal)
   );

   assign unused_instr_bits = ^bus.instr[25:6];

   assign waiting = ((state_q == ST_FETCH) && !bus.instr_ack) ||
                    ((state_q == ST_MEM)   && !bus.dmem_ack);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ctrl_d    = ctrl_q;
      illegal_d = illegal_q;
      if (!stall) begin
         case (state_q)
            ST_FETCH: begin
               if (bus.instr_ack) begin
                  state_d   = ST_DECODE;
                  ctrl_d    = dec_ctrl;
                  illegal_d = dec_illegal;
               end
            end
            ST_DECODE: state_d = illegal_q ? ST_TRAP : ST_EXEC;
            ST_EXEC: begin
               if (ctrl_q.mem_to_reg || ctrl_q.mem_wr) begin
                  state_d = ST_MEM;
               end else if (ctrl_q.branch || ctrl_q.jump) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end
            ST_MEM: begin
               if (bus.dmem_ack) begin
                  state_d = ctrl_q.mem_wr ? ST_FETCH : ST_WB;
               end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = state_q;
         endcase

         if ((TIMEOUT != 0) && waiting) begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_BUSERR;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            cnt_d = '0;
         end

         // Controls are held only for the life of one instruction
         if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) begin
            ctrl_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_FETCH;
         cnt_q     <= '0;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
      end
   end

   // Pulses that complete on an ack must appear in the ack cycle, so they combine the state register with the ack
   assign ir_wr  = reset_n && !stall && (state_q == ST_FETCH) && bus.instr_ack;
   assign pc_wr  = !stall && (((state_q == ST_EXEC) && (ctrl_q.branch || ctrl_q.jump)) ||
                              ((state_q == ST_MEM) && bus.dmem_ack && ctrl_q.mem_wr) ||
                              (state_q == ST_WB));
   assign reg_wr = !stall && (((state_q == ST_EXEC) && ctrl_q.jal_instr) || (state_q == ST_WB));

   assign bus.instr_req = (state_q == ST_FETCH);
   assign bus.dmem_req  = (state_q == ST_MEM);
   assign bus.dmem_wr   = (state_q == ST_MEM) && ctrl_q.mem_wr;

   assign reg_dst         = ctrl_q.reg_dst;
   assign alu_src         = ctrl_q.alu_src;
   assign ext_op          = ctrl_q.ext_op;
   assign mem_to_reg      = ctrl_q.mem_to_reg;
   assign branch          = ctrl_q.branch;
   assign branch_ne       = ctrl_q.branch_ne;
   assign jump            = ctrl_q.jump;
   assign jal_instr       = ctrl_q.jal_instr;
   assign mem_byte_op     = ctrl_q.mem_byte_op;
   assign mem_halfword_op = ctrl_q.mem_halfword_op;
   assign mem_sign_ext    = ctrl_q.mem_sign_ext;
   assign alu_ctrl        = ALU_CTRL_W'(ctrl_q.alu_ctrl);

   assign illegal_instr = (state_q == ST_TRAP);
   assign bus_error     = (state_q == ST_BUSERR);
   assign state         = state_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle successor to the single-cycle control decoder. It sequences each MIPS-subset instruction through FETCH/DECODE/EXEC/MEM/WB states, with req/ack handshakes to instruction and data memory, a parametrised ack timeout, and a global stall. Every control output is registered. It drives the same datapath control set as the single-cycle decoder, plus write-enable pulses and error flags.

Parameters:
TIMEOUT, 16, max cycles waiting for instr_ack/dmem_ack before bus error; 0 disables the timeout.
ALU_CTRL_W, 4, width of alu_ctrl.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
stall  in  1  freeze FSM; suppress pulses
instr  in  32  instruction word, valid with instr_ack
instr_ack  in  1  imem completes fetch
dmem_ack  in  1  dmem completes access
instr_req  out  1  fetch request
dmem_req  out  1  data access request
dmem_wr  out  1  access is a store (valid with dmem_req)
ir_wr  out  1  latch instr into IR (pulse)
pc_wr  out  1  update PC (pulse, last cycle of instruction)
reg_wr  out  1  register write (pulse)
reg_dst, alu_src, ext_op, mem_to_reg, branch, branch_ne, jump, jal_instr, mem_byte_op, mem_halfword_op, mem_sign_ext  out  1 each  datapath controls, held DECODE..end of instruction
alu_ctrl  out  ALU_CTRL_W  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1001, LUI 1010
illegal_instr  out  1  sticky trap flag
bus_error  out  1  sticky timeout flag
state  out  3  current state (debug)

Behaviour:
- Reset (async, any state): state=FETCH(0); all outputs 0 except instr_req=1; timeout counter=0; sticky flags cleared.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, BUSERR=6.
- FETCH: instr_req=1. On instr_ack: IR captured, ir_wr=1 that cycle, next state DECODE. A same-cycle ack is legal.
- DECODE: opcode/funct decoded from IR; control outputs registered. Unknown opcode/funct goes to TRAP; otherwise goes to EXEC.
- Supported: R-type add 20, sub 22, and 24, or 25, slt 2a, sll 00, srl 02; addi 08, andi 0c, ori 0d, lui 0f; lw 23, lb 20, lbu 24, lh 21, lhu 25; sw 2b, sb 28, sh 29; beq 04, bne 05; j 02, jal 03 (hex).
- ext_op=1 for addi, loads, stores, branches. alu_src=1 for I-type ALU ops and memory ops. reg_dst=1 for R-type only.
- EXEC, ALU op: next state WB.
- EXEC, load/store: next state MEM.
- EXEC, beq/bne: branch=1 (branch_ne=1 for bne), alu_ctrl=SUB, pc_wr=1, next state FETCH.
- EXEC, j: jump=1, pc_wr=1, next state FETCH.
- EXEC, jal: jump=1, jal_instr=1, reg_wr=1, pc_wr=1, next state FETCH.
- MEM: dmem_req=1 held until dmem_ack; dmem_wr=1 for stores. On ack, a store asserts pc_wr and goes to FETCH; a load goes to WB.
- WB: reg_wr=1 and pc_wr=1 for one cycle; mem_to_reg=1 for loads; next state FETCH.
- CPI with zero-wait acks: ALU 4, load 5, store 4, branch/jump 3.
- Timeout: counter increments each cycle in FETCH/MEM without ack and clears on ack or state change. When it reaches TIMEOUT: bus_error=1, state=BUSERR, requests dropped. BUSERR and TRAP are absorbing until reset.
- stall=1: state, counter and held controls frozen; ir_wr/pc_wr/reg_wr forced 0; req lines held. An ack arriving during a stall is ignored, and the memory must hold it. Stall has priority over ack and timeout.
- Ack while not requesting is ignored.

Decomposition:
- Shared package: opcode and funct constants, state encoding, ALU_CTRL codes, control-bundle struct.
- One sub-module, instr_decoder: combinational IR→control bundle plus illegal flag. The FSM, counter and pulse generation live in the top.

Test Plan:
- add 0x00221820, instr_ack tied 1 → ir_wr at cycle 0; reg_dst=1, alu_ctrl=0010; reg_wr=pc_wr=1 at cycle 3 (WB); instr_req reasserted at cycle 4.
- addi 0x20230008 → alu_src=1, ext_op=1, reg_dst=0, alu_ctrl=0010; reg_wr at cycle 3. jal 0x0c00000c → cycle 2: jump=jal_instr=reg_wr=pc_wr=1.
- beq 0x10800000 → cycle 2: branch=1, branch_ne=0, alu_ctrl=0110, pc_wr=1, no reg_wr. lw 0x8c220004 with dmem_ack 3 cycles late → dmem_req held 4 cycles, mem_to_reg=1, reg_wr one cycle after ack.
- TIMEOUT=8, instr_ack held 0 → bus_error=1 and state=6 exactly 8 cycles after reset release; stays there. Opcode 0x3f → illegal_instr=1, state=5.
- stall=1 for 5 cycles during MEM with dmem_ack=1 → no state change, no pulses. Reset asserted mid-MEM → same-instant FETCH, all flags 0.
